// File: rtl/tqvp_trng_health_reader.sv
// TRNG consumer: RCT/APT health tests, byte packer and FIFO behind the TinyQV peripheral bus.
// Define TRNG_VON_NEUMANN_EN to feed the packer through a Von Neumann debiaser.
module tqvp_trng_health_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RCT_CUTOFF = 16,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_bit,
    input  logic       raw_valid,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    input  logic       data_read,
    output logic [7:0] data_out,
    output logic [7:0] uo_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned WIN_W = $clog2(APT_WINDOW);
    localparam logic [7:0]       RCT_CUT  = 8'(RCT_CUTOFF);
    localparam logic [8:0]       APT_CUT  = 9'(APT_CUTOFF);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Register bus decode
    logic ctrl_wr, clear, flush;
    logic unused_data_in;
    assign ctrl_wr        = data_write & (address == 4'd2);
    assign clear          = ctrl_wr & data_in[1];
    assign flush          = ctrl_wr & data_in[2];
    assign unused_data_in = ^data_in[7:3];

    // Health test state
    logic [7:0]       rct_run_q, rct_run_d;
    logic             rct_last_q, rct_last_d;
    logic [WIN_W-1:0] apt_pos_q, apt_pos_d;
    logic             apt_ref_q, apt_ref_d;
    logic [8:0]       apt_cnt_q, apt_cnt_d;
    logic             rct_fail_q, apt_fail_q, overflow_q, enable_q;
    logic             rct_trip, apt_trip, health_fail;

    assign health_fail = rct_fail_q | apt_fail_q;

    always_comb begin
        rct_run_d  = rct_run_q;
        rct_last_d = rct_last_q;
        apt_pos_d  = apt_pos_q;
        apt_ref_d  = apt_ref_q;
        apt_cnt_d  = apt_cnt_q;
        rct_trip   = 1'b0;
        apt_trip   = 1'b0;
        if (raw_valid) begin
            rct_last_d = raw_bit;
            // A zero run length means no bit seen since reset/CLEAR
            if (rct_run_q == 8'd0 || raw_bit != rct_last_q) begin
                rct_run_d = 8'd1;
            end else if (rct_run_q != 8'hFF) begin
                rct_run_d = rct_run_q + 8'd1;
            end
            rct_trip = (rct_run_d >= RCT_CUT);

            if (apt_pos_q == '0) begin
                apt_ref_d = raw_bit;
                apt_cnt_d = 9'd1;
            end else if (raw_bit == apt_ref_q) begin
                apt_cnt_d = apt_cnt_q + 9'd1;
            end
            apt_pos_d = apt_pos_q + WIN_W'(1);
            apt_trip  = (apt_cnt_d >= APT_CUT);
        end
    end

    // Packer input, optionally debiased
    logic pk_valid, pk_bit;
`ifdef TRNG_VON_NEUMANN_EN
    logic vn_phase_q, vn_first_q;
    assign pk_valid = enable_q & raw_valid & vn_phase_q & (vn_first_q != raw_bit);
    assign pk_bit   = vn_first_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vn_phase_q <= 1'b0;
            vn_first_q <= 1'b0;
        end else if (flush || !enable_q) begin
            vn_phase_q <= 1'b0;
        end else if (raw_valid) begin
            vn_phase_q <= ~vn_phase_q;
            if (!vn_phase_q) vn_first_q <= raw_bit;
        end
    end
`else
    assign pk_valid = enable_q & raw_valid;
    assign pk_bit   = raw_bit;
`endif

    logic [2:0] pk_cnt_q, pk_cnt_d;
    logic [7:0] pk_byte_q, pk_byte_d;
    logic       push_req;

    always_comb begin
        pk_cnt_d  = pk_cnt_q;
        pk_byte_d = pk_byte_q;
        if (flush) begin
            pk_cnt_d = 3'd0;
        end else if (pk_valid) begin
            pk_cnt_d  = pk_cnt_q + 3'd1;
            pk_byte_d = {pk_bit, pk_byte_q[7:1]};
        end
    end

    // A byte completed by (or after) a failing bit is discarded
    assign push_req = pk_valid & (pk_cnt_q == 3'd7) & ~health_fail & ~rct_trip & ~apt_trip
                      & ~flush;

    // FIFO
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_empty, fifo_full, pop_req, do_push, overflow_evt;

    assign fifo_empty   = (level_q == '0);
    assign fifo_full    = (level_q == LVL_FULL);
    assign pop_req      = data_read & (address == 4'd0) & ~fifo_empty & ~flush;
    assign do_push      = push_req & (~fifo_full | pop_req);
    assign overflow_evt = push_req & fifo_full & ~pop_req;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_req) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !pop_req) level_d = level_q + LVL_W'(1);
            else if (!do_push && pop_req) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= pk_byte_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rct_run_q  <= 8'd0;
            rct_last_q <= 1'b0;
            apt_pos_q  <= '0;
            apt_ref_q  <= 1'b0;
            apt_cnt_q  <= 9'd0;
            rct_fail_q <= 1'b0;
            apt_fail_q <= 1'b0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b0;
            pk_cnt_q   <= 3'd0;
            pk_byte_q  <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            if (clear) begin
                rct_run_q  <= 8'd0;
                apt_pos_q  <= '0;
                apt_cnt_q  <= 9'd0;
                rct_fail_q <= 1'b0;
                apt_fail_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                rct_run_q  <= rct_run_d;
                rct_last_q <= rct_last_d;
                apt_pos_q  <= apt_pos_d;
                apt_ref_q  <= apt_ref_d;
                apt_cnt_q  <= apt_cnt_d;
                if (rct_trip) rct_fail_q <= 1'b1;
                if (apt_trip) apt_fail_q <= 1'b1;
                if (overflow_evt) overflow_q <= 1'b1;
            end
            if (ctrl_wr) enable_q <= data_in[0];
            pk_cnt_q  <= pk_cnt_d;
            pk_byte_q <= pk_byte_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'd0:    data_out = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
            4'd1:    data_out = {3'b000, overflow_q, apt_fail_q, rct_fail_q, fifo_full, fifo_empty};
            4'd2:    data_out = {7'b0, enable_q};
            4'd3:    data_out = {{(8 - LVL_W){1'b0}}, level_q};
            default: data_out = 8'h00;
        endcase
    end

    assign uo_out = {5'b00000, overflow_q, health_fail, ~fifo_empty};

endmodule
